// File: rtl/opsum_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// opsum_fifo_ctrl
// Drain-side controller for the output-psum FIFO. It pops psums fed by the PE
// array, requests GLB write slots from the arbiter, and writes each psum as
// one 16-bit half-word to consecutive GLB byte addresses from a per-tile base.
//
// Optional feature macro: OPSUM_RELU_EN
//   defined   -> psums are treated as signed and negative values are written
//                as zero (ReLU before lane mapping)
//   undefined -> psums are written unmodified
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   opsum_fifo_reset_i         synchronous clear of state, counters, pointer
//   opsum_need_drain_i         start a drain task (sampled in IDLE only)
//   opsum_drain_num_i          number of psums in this task
//   opsum_fifo_base_addr_i     GLB byte base address (bit 0 ignored)
//   fifo_glb_busy_i            GLB port busy with another FIFO
//   opsum_fifo_empty_i         opsum FIFO empty
//   opsum_fifo_pop_data_i      FIFO head (first-word-fall-through)
//   opsum_fifo_pop_o           pop strobe
//   opsum_write_req_o          write request to arbiter
//   opsum_permit_write_i       arbiter grant for this cycle
//   opsum_glb_write_addr_o     GLB byte address
//   opsum_glb_write_data_o     GLB write data
//   opsum_glb_web_o            byte write enables, active high
//   opsum_is_DRAIN_state_o     high in DRAIN (FSM state visibility)
//   opsum_fifo_done_o          high in IDLE  (FSM state visibility)
//
// Handshake: opsum_write_req_o is a valid-style request that depends only on
// current state and inputs; a write fires in any cycle where request and
// opsum_permit_write_i are both high. The pop, byte enables, data and address
// of that write are presented in the same cycle; the GLB captures them on the
// next clock edge. A permit without a request has no effect.
// -----------------------------------------------------------------------------
module opsum_fifo_ctrl #(
  parameter int PSUM_W    = 16,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              opsum_fifo_reset_i,
  input  logic              opsum_need_drain_i,
  input  logic [31:0]       opsum_drain_num_i,
  input  logic [31:0]       opsum_fifo_base_addr_i,
  input  logic              fifo_glb_busy_i,
  input  logic              opsum_fifo_empty_i,
  input  logic [PSUM_W-1:0] opsum_fifo_pop_data_i,
  output logic              opsum_fifo_pop_o,
  output logic              opsum_write_req_o,
  input  logic              opsum_permit_write_i,
  output logic [31:0]       opsum_glb_write_addr_o,
  output logic [31:0]       opsum_glb_write_data_o,
  output logic [3:0]        opsum_glb_web_o,
  output logic              opsum_is_DRAIN_state_o,
  output logic              opsum_fifo_done_o
);

  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     drain_num_q, drain_num_d;
  logic [31:0]     wr_cnt_q, wr_cnt_d;
  logic [31:0]     wr_ptr_q, wr_ptr_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;

  logic            req;
  logic            fire;
  logic [31:0]     addr;
  logic [PSUM_W-1:0] psum_w;

  // Request is purely combinational; the burst cap forces one idle cycle
  // after BURST_MAX back-to-back grants because burst_cnt clears on that gap.
  assign req = (state_q == S_DRAIN) && !opsum_fifo_reset_i && !opsum_fifo_empty_i &&
               !fifo_glb_busy_i && (burst_cnt_q < BW'(BURST_MAX)) &&
               (wr_cnt_q < drain_num_q);
  assign fire = req && opsum_permit_write_i;

  // Half-word addressing: base aligned to 2 bytes, pointer counts half-words.
  assign addr = {opsum_fifo_base_addr_i[31:1], 1'b0} + (wr_ptr_q << 1);

`ifdef OPSUM_RELU_EN
  assign psum_w = opsum_fifo_pop_data_i[PSUM_W-1] ? '0 : opsum_fifo_pop_data_i;
`else
  assign psum_w = opsum_fifo_pop_data_i;
`endif

  assign opsum_write_req_o      = req;
  assign opsum_fifo_pop_o       = fire;
  assign opsum_glb_write_addr_o = addr;
  assign opsum_glb_web_o        = !fire   ? 4'b0000 :
                                  addr[1] ? 4'b1100 : 4'b0011;
  assign opsum_glb_write_data_o = !fire   ? 32'h0 :
                                  addr[1] ? {psum_w, 16'h0000} : {16'h0000, psum_w};
  assign opsum_is_DRAIN_state_o = (state_q == S_DRAIN);
  assign opsum_fifo_done_o      = (state_q == S_IDLE);

  always_comb begin
    state_d     = state_q;
    drain_num_d = drain_num_q;
    wr_cnt_d    = wr_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    burst_cnt_d = fire ? burst_cnt_q + BW'(1) : '0;

    if (fire) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
      wr_ptr_d = wr_ptr_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        wr_cnt_d = '0;
        // A zero-length task is dropped so no request is ever raised.
        if (opsum_need_drain_i && (opsum_drain_num_i != 32'd0)) begin
          drain_num_d = opsum_drain_num_i;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_glb_busy_i) begin
          state_d = S_WAIT;
        end else if (fire && (wr_cnt_q == drain_num_q - 32'd1)) begin
          state_d  = S_IDLE;
          wr_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (!fifo_glb_busy_i) state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase

    if (opsum_fifo_reset_i) begin
      state_d     = S_IDLE;
      drain_num_d = '0;
      wr_cnt_d    = '0;
      wr_ptr_d    = '0;
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      drain_num_q <= '0;
      wr_cnt_q    <= '0;
      wr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_num_q <= drain_num_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_opsum_fifo_ctrl.sv
module tb_opsum_fifo_ctrl;

  localparam int BURST_MAX = 4;

  // ---------------------------------------------------------------- clock/reset
  logic        clk;
  logic        rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT signals
  logic        fifo_rst;
  logic        need_drain;
  logic [31:0] drain_num;
  logic [31:0] base_addr;
  logic        busy;
  logic        empty;
  logic [15:0] pop_data;
  logic        pop;
  logic        req;
  logic        permit;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  web;
  logic        is_drain;
  logic        done;

  opsum_fifo_ctrl #(.PSUM_W(16), .BURST_MAX(BURST_MAX)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .opsum_fifo_reset_i     (fifo_rst),
    .opsum_need_drain_i     (need_drain),
    .opsum_drain_num_i      (drain_num),
    .opsum_fifo_base_addr_i (base_addr),
    .fifo_glb_busy_i        (busy),
    .opsum_fifo_empty_i     (empty),
    .opsum_fifo_pop_data_i  (pop_data),
    .opsum_fifo_pop_o       (pop),
    .opsum_write_req_o      (req),
    .opsum_permit_write_i   (permit),
    .opsum_glb_write_addr_o (waddr),
    .opsum_glb_write_data_o (wdata),
    .opsum_glb_web_o        (web),
    .opsum_is_DRAIN_state_o (is_drain),
    .opsum_fifo_done_o      (done)
  );

  // ---------------------------------------------------------------- bench state
  logic [15:0] fifo_q[$];   // contents of the external opsum FIFO
  logic [15:0] exp_q[$];    // expected half-word for each pushed psum
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic [3:0]  cap_web[$];
  int          checks;
  int          errors;
  int          pop_cnt;
  bit          force_empty;
  bit          last_req;

  // Reference model: a task is active or not, may be parked waiting on busy,
  // has a number of psums left, a run length of back-to-back writes, and a
  // half-word pointer that survives across tasks.
  bit          m_active;
  bit          m_wait;
  int unsigned m_left;
  int unsigned m_run;
  logic [31:0] m_ptr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] relu_ref(input logic [15:0] p);
`ifdef OPSUM_RELU_EN
    return ($signed(p) < 0) ? 16'h0000 : p;
`else
    return p;
`endif
  endfunction

  function automatic logic [15:0] lane(input logic [31:0] d, input logic [3:0] w);
    return (w == 4'b1100) ? d[31:16] : d[15:0];
  endfunction

  task automatic push(input logic [15:0] p);
    fifo_q.push_back(p);
    exp_q.push_back(relu_ref(p));
  endtask

  task automatic model_reset();
    m_active = 0;
    m_wait   = 0;
    m_left   = 0;
    m_run    = 0;
    m_ptr    = '0;
  endtask

  task automatic clear_caps();
    cap_addr.delete();
    cap_data.delete();
    cap_web.delete();
    pop_cnt = 0;
  endtask

  // One clock cycle: present inputs, check combinational outputs against the
  // model before the edge, then advance the model and the bench FIFO.
  task automatic cycle();
    bit          exp_req;
    bit          exp_fire;
    logic [31:0] ea;
    logic [15:0] ev;
    logic [3:0]  ew;
    empty    = force_empty || (fifo_q.size() == 0);
    pop_data = (fifo_q.size() != 0) ? fifo_q[0] : 16'hBEEF;
    #2;
    exp_req  = !fifo_rst && m_active && !m_wait && !busy && !empty &&
               (m_run < BURST_MAX) && (m_left > 0);
    exp_fire = exp_req && permit;
    last_req = req;
    chk("req", {31'd0, req}, {31'd0, exp_req});
    chk("pop", {31'd0, pop}, {31'd0, exp_fire});
    chk("done", {31'd0, done}, {31'd0, !m_active});
    chk("is_drain", {31'd0, is_drain}, {31'd0, m_active && !m_wait});
    if (exp_fire) begin
      ea = {base_addr[31:1], 1'b0} + (m_ptr * 32'd2);
      ew = ea[1] ? 4'b1100 : 4'b0011;
      ev = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      chk("addr", waddr, ea);
      chk("web", {28'd0, web}, {28'd0, ew});
      chk("data", wdata, ea[1] ? {ev, 16'h0000} : {16'h0000, ev});
    end else begin
      chk("web_idle", {28'd0, web}, 32'd0);
    end
    if (pop) begin
      pop_cnt++;
      cap_addr.push_back(waddr);
      cap_data.push_back(wdata);
      cap_web.push_back(web);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    @(posedge clk);
    if (fifo_rst) begin
      model_reset();
    end else begin
      if (exp_fire) begin
        m_ptr  = m_ptr + 32'd1;
        m_left = m_left - 1;
        m_run  = m_run + 1;
      end else begin
        m_run = 0;
      end
      if (!m_active) begin
        if (need_drain && drain_num != 0) begin
          m_active = 1;
          m_left   = drain_num;
        end
      end else if (!m_wait) begin
        if (busy) m_wait = 1;
        else if (exp_fire && m_left == 0) m_active = 0;
      end else if (!busy) begin
        m_wait = 0;
      end
    end
    #1;
  endtask

  task automatic start(input int unsigned n);
    need_drain = 1'b1;
    drain_num  = n;
    cycle();
    need_drain = 1'b0;
  endtask

  task automatic run_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!m_active) break;
      cycle();
    end
    chk("drain_timeout", {31'd0, done}, 32'd1);
  endtask

  // ---------------------------------------------------------------- stimulus
  int p0;
  logic [6:0] pat;

  initial begin
    checks = 0; errors = 0; pop_cnt = 0;
    rst_n = 1'b0; fifo_rst = 1'b0; need_drain = 1'b0; drain_num = '0;
    base_addr = '0; busy = 1'b0; permit = 1'b0; force_empty = 0;
    empty = 1'b1; pop_data = '0;
    model_reset();
    #3;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_pop", {31'd0, pop}, 32'd0);
    chk("rst_web", {28'd0, web}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd1);
    chk("rst_drain", {31'd0, is_drain}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic drain
    base_addr = 32'h100; permit = 1'b1;
    push(16'h1111); push(16'h2222); push(16'h3333);
    clear_caps();
    start(3);
    run_idle(20);
    chk("t1_pops", pop_cnt, 3);
    chk("t1_addr0", cap_addr[0], 32'h100);
    chk("t1_web0", {28'd0, cap_web[0]}, 32'h3);
    chk("t1_data0", cap_data[0], 32'h00001111);
    chk("t1_addr1", cap_addr[1], 32'h102);
    chk("t1_web1", {28'd0, cap_web[1]}, 32'hC);
    chk("t1_data1", cap_data[1], 32'h22220000);
    chk("t1_addr2", cap_addr[2], 32'h104);

    // Burst cap
    base_addr = 32'h200;
    for (int i = 0; i < 6; i++) push(16'(i + 16'h0A00));
    clear_caps();
    start(6);
    pat = '0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      pat = {pat[5:0], last_req};
    end
    chk("t2_req_pattern", {25'd0, pat}, {25'd0, 7'b1111011});
    run_idle(20);
    chk("t2_pops", pop_cnt, 6);

    // Busy and empty stalls, pointer cleared first
    fifo_rst = 1'b1; cycle(); fifo_rst = 1'b0;
    base_addr = 32'h400;
    for (int i = 0; i < 5; i++) push(16'($urandom));
    clear_caps();
    start(5);
    cycle(); cycle();
    busy = 1'b1;
    cycle(); cycle();
    chk("t3_wait_not_drain", {31'd0, is_drain}, 32'd0);
    chk("t3_wait_not_done", {31'd0, done}, 32'd0);
    busy = 1'b0;
    cycle(); cycle();
    chk("t3_resume_addr", cap_addr[2], 32'h404);
    p0 = pop_cnt;
    force_empty = 1;
    cycle(); cycle(); cycle();
    chk("t3_empty_nopop", pop_cnt - p0, 0);
    force_empty = 0;
    run_idle(30);
    chk("t3_pops", pop_cnt, 5);

    // Zero-length task
    p0 = pop_cnt;
    push(16'h5555);
    start(0);
    cycle(); cycle(); cycle();
    chk("t4_zero_done", {31'd0, done}, 32'd1);
    chk("t4_zero_nopop", pop_cnt - p0, 0);

    // Synchronous clear mid-task; next task restarts at base
    base_addr = 32'h300;
    for (int i = 0; i < 3; i++) push(16'($urandom));
    start(4);
    cycle(); cycle();
    fifo_rst = 1'b1; cycle(); fifo_rst = 1'b0;
    chk("t4_clr_done", {31'd0, done}, 32'd1);
    clear_caps();
    start(2);
    run_idle(20);
    chk("t4_clr_base", cap_addr[0], 32'h300);

    // Async reset mid-task
    for (int i = 0; i < 4; i++) push(16'($urandom));
    start(4);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_arst_req", {31'd0, req}, 32'd0);
    chk("t4_arst_pop", {31'd0, pop}, 32'd0);
    chk("t4_arst_web", {28'd0, web}, 32'd0);
    chk("t4_arst_done", {31'd0, done}, 32'd1);
    fifo_q.delete(); exp_q.delete();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Permit without request, and need_drain ignored during DRAIN
    base_addr = 32'h500;
    push(16'h7777);
    p0 = pop_cnt;
    cycle(); cycle();
    chk("t5_permit_idle_nopop", pop_cnt - p0, 0);
    for (int i = 0; i < 3; i++) push(16'($urandom));
    clear_caps();
    start(4);
    need_drain = 1'b1; drain_num = 32'd1;
    cycle();
    need_drain = 1'b0;
    run_idle(20);
    chk("t5_latched_count", pop_cnt, 4);

    // Sign handling of the psum
    push(16'hFF80); push(16'h007F);
    clear_caps();
    start(2);
    run_idle(20);
`ifdef OPSUM_RELU_EN
    chk("t6_neg", {16'd0, lane(cap_data[0], cap_web[0])}, 32'h0000);
`else
    chk("t6_neg", {16'd0, lane(cap_data[0], cap_web[0])}, 32'hFF80);
`endif
    chk("t6_pos", {16'd0, lane(cap_data[1], cap_web[1])}, 32'h007F);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      permit      = ($urandom_range(0, 9) < 7);
      busy        = ($urandom_range(0, 9) == 0);
      force_empty = ($urandom_range(0, 9) == 0);
      fifo_rst    = ($urandom_range(0, 49) == 0);
      need_drain  = ($urandom_range(0, 9) < 3);
      drain_num   = $urandom_range(0, 8);
      if ($urandom_range(0, 19) == 0) base_addr = $urandom;
      if (fifo_q.size() < 12 && $urandom_range(0, 1) == 1) push(16'($urandom));
      cycle();
    end
    permit = 1'b1; busy = 1'b0; force_empty = 0; fifo_rst = 1'b0; need_drain = 1'b0;
    for (int i = 0; i < 10; i++) push(16'($urandom));
    run_idle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1);
  end

endmodule
